// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data memory controller
package data_mem_pkg;
    typedef enum logic [1:0] {IDLE, STROBE, GAP, DONE} state_t;
    typedef enum logic {REQ_PIPE, REQ_ACC} req_id_t;
    localparam int BEATS_WORD = 4;
    localparam int BEATS_BYTE = 1;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: two-input round-robin arbiter; pointer remembers the last grant
import data_mem_pkg::*;

module mem_rr_arb (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    req_p,
    input  logic    req_a,
    output logic    grant_valid,
    output req_id_t grant
);
    req_id_t last;

    assign grant_valid = req_p || req_a;
    assign grant = (req_p && req_a) ? ((last == REQ_PIPE) ? REQ_ACC : REQ_PIPE)
                                    : (req_a ? REQ_ACC : REQ_PIPE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= REQ_ACC;
        else if (en && grant_valid)
            last <= grant;
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: arbitrates two requesters and sequences byte-beat strobes into data_Mem
import data_mem_pkg::*;

module data_mem_ctrl #(
    parameter int N      = 32,
    parameter int ADDR_W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         p_req,
    input  logic         p_we,
    input  logic         p_byte,
    input  logic [N-1:0] p_addr,
    input  logic [N-1:0] p_wdata,
    output logic [N-1:0] p_rdata,
    output logic         p_done,
    input  logic         a_req,
    input  logic         a_we,
    input  logic         a_byte,
    input  logic [N-1:0] a_addr,
    input  logic [N-1:0] a_wdata,
    output logic [N-1:0] a_rdata,
    output logic         a_done,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_re,
    output logic         mem_we,
    output logic         mem_isbyte
);
    state_t              state, state_next;
    req_id_t             grant, id_q;
    logic                grant_valid, start;
    logic [1:0]          beat, last_beat, nb;
    logic                we_q, byte_q, wflag;
    logic [ADDR_W-1:0]   addr_q, base, beat_addr;
    logic [N-1:0]        wdata_q, wsrc, buf_q, buf_next, rdata_out;
    logic                sel_we, sel_byte;
    logic [N-1:0]        sel_addr, sel_wdata;
    logic                re_d, we_d, isbyte_d, p_done_d, a_done_d;
    logic [N-1:0]        addr_d, wdata_d, p_rdata_d, a_rdata_d;
    logic                unused_bits;

    assign unused_bits = ^{mem_rdata[N-1:BYTE_W], sel_addr[N-1:ADDR_W]};

    mem_rr_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (start),
        .req_p       (p_req),
        .req_a       (a_req),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign start     = (state == IDLE) && grant_valid;
    assign sel_we    = (grant == REQ_ACC) ? a_we    : p_we;
    assign sel_byte  = (grant == REQ_ACC) ? a_byte  : p_byte;
    assign sel_addr  = (grant == REQ_ACC) ? a_addr  : p_addr;
    assign sel_wdata = (grant == REQ_ACC) ? a_wdata : p_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = grant_valid ? STROBE : IDLE;
            STROBE:  state_next = GAP;
            GAP:     state_next = (beat == last_beat) ? DONE : STROBE;
            default: state_next = IDLE;
        endcase
    end

    // Next beat's address/lane come from the request itself on grant, else from the latched copy
    always_comb begin
        nb        = start ? 2'd0 : beat + 2'd1;
        base      = start ? sel_addr[ADDR_W-1:0] : addr_q;
        wsrc      = start ? sel_wdata : wdata_q;
        wflag     = start ? sel_we : we_q;
        beat_addr = base + ADDR_W'(nb);
        buf_next  = buf_q;
        if (state == GAP && !we_q)
            buf_next[BYTE_W*beat +: BYTE_W] = mem_rdata[BYTE_W-1:0];
        rdata_out = byte_q ? {{(N-BYTE_W){1'b0}}, buf_next[BYTE_W-1:0]} : buf_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= 2'd0;
            last_beat <= 2'd0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            id_q      <= REQ_PIPE;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
        end else if (start) begin
            beat      <= 2'd0;
            last_beat <= sel_byte ? 2'(BEATS_BYTE - 1) : 2'(BEATS_WORD - 1);
            we_q      <= sel_we;
            byte_q    <= sel_byte;
            id_q      <= grant;
            addr_q    <= sel_addr[ADDR_W-1:0];
            wdata_q   <= sel_wdata;
        end else if (state == GAP) begin
            buf_q     <= buf_next;
            beat      <= (beat == last_beat) ? beat : beat + 2'd1;
        end
    end

    // Outputs are computed for the state being entered, then registered
    always_comb begin
        re_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        isbyte_d  = mem_isbyte;
        p_done_d  = 1'b0;
        a_done_d  = 1'b0;
        p_rdata_d = p_rdata;
        a_rdata_d = a_rdata;
        if (state_next == STROBE) begin
            re_d     = !wflag;
            we_d     = wflag;
            addr_d   = {{(N-ADDR_W){1'b0}}, beat_addr};
            wdata_d  = {{(N-BYTE_W){1'b0}}, wsrc[BYTE_W*nb +: BYTE_W]};
            isbyte_d = start ? sel_byte : byte_q;
        end
        if (state_next == DONE) begin
            p_done_d  = (id_q == REQ_PIPE);
            a_done_d  = (id_q == REQ_ACC);
            p_rdata_d = (id_q == REQ_PIPE) ? rdata_out : p_rdata;
            a_rdata_d = (id_q == REQ_ACC) ? rdata_out : a_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_isbyte <= 1'b0;
            p_done     <= 1'b0;
            a_done     <= 1'b0;
            p_rdata    <= '0;
            a_rdata    <= '0;
        end else begin
            mem_re     <= re_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_isbyte <= isbyte_d;
            p_done     <= p_done_d;
            a_done     <= a_done_d;
            p_rdata    <= p_rdata_d;
            a_rdata    <= a_rdata_d;
        end
    end
endmodule
